// File: rtl/flag_register.sv
// rtl/flag_register.sv - NZCV status register with in-flight flag-setter tracking
// Flags/Flags_Fwd/Load_Data are packed {C,N,V,Z}.
module flag_register #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Alu_Result,
    input  logic        Alu_Carry,
    input  logic        Alu_Overflow,
    input  logic        Shifter_Carry,
    input  logic        Logical_Op,
    input  logic        Wb_Valid,
    input  logic        S_Bit,
    input  logic        Cond_Pass,
    input  logic        Issue_Set,
    input  logic        Load_En,
    input  logic [3:0]  Load_Data,
    output logic [3:0]  Flags,
    output logic [3:0]  Flags_Fwd,
    output logic        Flags_Pending,
    output logic        Issue_Stall,
    output logic        Count_Err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             retire;
    logic             update;
    logic [3:0]       computed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;

    assign retire = Wb_Valid & S_Bit;
    assign update = retire & Cond_Pass;

    // Logical ops take C from the shifter and leave V untouched.
    assign computed = {Logical_Op ? Shifter_Carry : Alu_Carry,
                       Alu_Result[31],
                       Logical_Op ? Flags[1] : Alu_Overflow,
                       (Alu_Result == 32'h0)};

    always_comb begin
        Flags_Fwd = Flags;
        if (Load_En)
            Flags_Fwd = Load_Data;
        else if (update)
            Flags_Fwd = computed;
    end

    // A failed-condition retire still leaves the pipe, so it decrements too.
    always_comb begin
        cnt_next = cnt;
        err_next = Count_Err;
        if (Issue_Set && !retire) begin
            if (cnt == MAX_CNT)
                err_next = 1'b1;
            else
                cnt_next = cnt + ONE;
        end else if (retire && !Issue_Set) begin
            if (cnt == '0)
                err_next = 1'b1;
            else
                cnt_next = cnt - ONE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Flags     <= 4'b0000;
            cnt       <= '0;
            Count_Err <= 1'b0;
        end else begin
            Flags     <= Flags_Fwd;
            cnt       <= cnt_next;
            Count_Err <= err_next;
        end
    end

    assign Flags_Pending = (cnt != '0);
    assign Issue_Stall   = (cnt == MAX_CNT) & !retire;

endmodule

// File: tb/tb_flag_register.sv
// tb/tb_flag_register.sv - table-driven scoreboard bench for flag_register
module tb_flag_register;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] Alu_Result = '0;
    logic        Alu_Carry = 1'b0, Alu_Overflow = 1'b0, Shifter_Carry = 1'b0;
    logic        Logical_Op = 1'b0, Wb_Valid = 1'b0, S_Bit = 1'b0, Cond_Pass = 1'b0;
    logic        Issue_Set = 1'b0, Load_En = 1'b0;
    logic [3:0]  Load_Data = '0;
    logic [3:0]  Flags, Flags_Fwd;
    logic        Flags_Pending, Issue_Stall, Count_Err;

    flag_register #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Alu_Result(Alu_Result), .Alu_Carry(Alu_Carry),
        .Alu_Overflow(Alu_Overflow), .Shifter_Carry(Shifter_Carry), .Logical_Op(Logical_Op),
        .Wb_Valid(Wb_Valid), .S_Bit(S_Bit), .Cond_Pass(Cond_Pass), .Issue_Set(Issue_Set),
        .Load_En(Load_En), .Load_Data(Load_Data), .Flags(Flags), .Flags_Fwd(Flags_Fwd),
        .Flags_Pending(Flags_Pending), .Issue_Stall(Issue_Stall), .Count_Err(Count_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wb, s, cp, lop;
        logic [31:0] res;
        logic        ac, av, sc, iss, ld;
        logic [3:0]  ldd;
        logic [3:0]  efwd;
        logic        estall;
        logic [3:0]  eflags;
        logic        epend, eerr;
    } vec_t;

    typedef struct {
        logic [3:0] flags;
        logic       pend, err;
        int         idx;
    } exp_t;

    vec_t tbl[23];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wb, s, cp, lop, input logic [31:0] res,
                                input logic ac, av, sc, iss, ld, input logic [3:0] ldd,
                                input logic [3:0] efwd, input logic estall,
                                input logic [3:0] eflags, input logic epend, eerr);
        vec_t v;
        v.wb = wb; v.s = s; v.cp = cp; v.lop = lop; v.res = res; v.ac = ac; v.av = av;
        v.sc = sc; v.iss = iss; v.ld = ld; v.ldd = ldd; v.efwd = efwd; v.estall = estall;
        v.eflags = eflags; v.epend = epend; v.eerr = eerr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Wb_Valid = v.wb; S_Bit = v.s; Cond_Pass = v.cp; Logical_Op = v.lop;
        Alu_Result = v.res; Alu_Carry = v.ac; Alu_Overflow = v.av; Shifter_Carry = v.sc;
        Issue_Set = v.iss; Load_En = v.ld; Load_Data = v.ldd;
    endtask

    // Comb outputs checked before the edge; registered expectations go through the scoreboard.
    task automatic apply(input vec_t v, input int idx);
        exp_t e, got;
        @(negedge Clk);
        drive(v);
        #1;
        chk($sformatf("fwd[%0d]", idx), 32'(Flags_Fwd), 32'(v.efwd));
        chk($sformatf("stall[%0d]", idx), 32'(Issue_Stall), 32'(v.estall));
        e.flags = v.eflags; e.pend = v.epend; e.err = v.eerr; e.idx = idx;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("flags[%0d]", got.idx), 32'(Flags), 32'(got.flags));
        chk($sformatf("pend[%0d]", got.idx), 32'(Flags_Pending), 32'(got.pend));
        chk($sformatf("err[%0d]", got.idx), 32'(Count_Err), 32'(got.err));
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,32'h0,0,0,0,0,0,4'h0, 4'h0,0,4'h0,0,0));
    endtask

    initial begin
        //          wb s cp lop res          ac av sc is ld ldd    fwd  st flags p e
        tbl[0]  = mk(0,0,0,0, 32'h0,        0,0,0, 0,0,4'h0, 4'h0,0,4'h0,0,0);
        tbl[1]  = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h0,0,4'h0,1,0);
        tbl[2]  = mk(1,1,1,0, 32'h0,        1,0,0, 0,0,4'h0, 4'h9,0,4'h9,0,0);
        tbl[3]  = mk(0,0,0,0, 32'h0,        0,0,0, 0,1,4'h2, 4'h2,0,4'h2,0,0);
        tbl[4]  = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h2,0,4'h2,1,0);
        tbl[5]  = mk(1,1,1,1, 32'h8000_0000,1,0,0, 0,0,4'h0, 4'h6,0,4'h6,0,0);
        tbl[6]  = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h6,0,4'h6,1,0);
        tbl[7]  = mk(1,1,0,0, 32'h0,        1,1,0, 0,0,4'h0, 4'h6,0,4'h6,0,0);
        tbl[8]  = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h6,0,4'h6,1,0);
        tbl[9]  = mk(1,1,1,0, 32'h0,        0,0,0, 0,1,4'hF, 4'hF,0,4'hF,0,0);
        tbl[10] = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'hF,0,4'hF,1,0);
        tbl[11] = mk(1,1,1,0, 32'hFFFF_0000,0,1,1, 0,0,4'h0, 4'h6,0,4'h6,0,0);
        tbl[12] = mk(1,0,1,0, 32'h0,        1,0,0, 0,0,4'h0, 4'h6,0,4'h6,0,0);
        tbl[13] = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h6,0,4'h6,1,0);
        tbl[14] = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h6,0,4'h6,1,0);
        tbl[15] = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h6,0,4'h6,1,0);
        tbl[16] = mk(0,0,0,0, 32'h0,        0,0,0, 0,0,4'h0, 4'h6,1,4'h6,1,0);
        tbl[17] = mk(0,0,0,0, 32'h0,        0,0,0, 1,0,4'h0, 4'h6,1,4'h6,1,1);
        tbl[18] = mk(1,1,0,0, 32'h0,        1,0,0, 1,0,4'h0, 4'h6,0,4'h6,1,1);
        tbl[19] = mk(1,1,0,0, 32'h0,        1,0,0, 0,0,4'h0, 4'h6,0,4'h6,1,1);
        tbl[20] = mk(1,1,0,0, 32'h0,        1,0,0, 0,0,4'h0, 4'h6,0,4'h6,1,1);
        tbl[21] = mk(1,1,0,0, 32'h0,        1,0,0, 0,0,4'h0, 4'h6,0,4'h6,0,1);
        tbl[22] = mk(0,0,0,0, 32'h0,        0,0,0, 0,0,4'h0, 4'h6,0,4'h6,0,1);

        #12;
        chk("rst_flags", 32'(Flags), 32'h0);
        chk("rst_fwd", 32'(Flags_Fwd), 32'h0);
        chk("rst_pend", 32'(Flags_Pending), 32'h0);
        chk("rst_stall", 32'(Issue_Stall), 32'h0);
        chk("rst_err", 32'(Count_Err), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 23; i++) apply(tbl[i], i);

        apply(mk(0,0,0,0, 32'h0,0,0,0, 0,1,4'hA, 4'hA,0,4'hA,0,1), 100);
        #2 Rst_n = 1'b0;
        idle();
        #1;
        chk("async_flags", 32'(Flags), 32'h0);
        chk("async_err", 32'(Count_Err), 32'h0);
        chk("async_pend", 32'(Flags_Pending), 32'h0);
        chk("async_fwd", 32'(Flags_Fwd), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Underflow: retire with nothing in flight still updates flags but flags the error.
        apply(mk(1,1,1,0, 32'h0,1,0,0, 0,0,4'h0, 4'h9,0,4'h9,0,1), 101);
        apply(mk(0,0,0,0, 32'h0,0,0,0, 0,0,4'h0, 4'h9,0,4'h9,0,1), 102);
        #2 Rst_n = 1'b0;
        #1;
        chk("async2_flags", 32'(Flags), 32'h0);
        chk("async2_err", 32'(Count_Err), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
